hop_chain_seq: RTL and testbench
================================

# hop_chain_seq

Bring-up controller for the multi-domain hop flop chain. On request it re-asserts every per-stage reset, releases the resets one domain at a time with a fixed gap, and holds the chain idle to confirm it is clean. It then injects a single-cycle start pulse with the enable held, measures the cycles until the pulse reaches the chain output, and reports pass/fail against the expected latency. It sits beside the chain and drives its resets, start and enable; the chain's tap/output feeds back into `chain_out`.

## Interface
- `NUM_RST`, 6: number of chain reset domains driven; `rst_out[k]` drives domain k+2.
- `REL_GAP`, 4: cycles between successive releases; also settle length; ≥1.
- `CHAIN_LAT`, 8: expected start→`chain_out` latency in cycles.
- `TO_CYCLES`, 32: timeout; must be > `CHAIN_LAT` and < 2^`CNT_W`−1.
- `CNT_W`, 6: width of latency counter and `lat_meas`.

Ports:
- `clock0`  in  1  clock.
- `rst1`  in  1  reset, asynchronous, active-high. Also drives chain domain 1 directly.
- `go`  in  1  start sequence; sampled only in IDLE.
- `chain_out`  in  1  chain output (last stage).
- `rst_out`  out  NUM_RST  per-domain active-high resets, registered.
- `start`  out  1  chain input pulse.
- `en`  out  1  last-stage enable.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  result of last run; held until next `go`.
- `lat_meas`  out  CNT_W  measured latency of last run; held.

## Operation
- Reset values: `rst_out`=all ones, `start`=0, `en`=0, `busy`=0, `done`=0, `pass`=0, `lat_meas`=0, state IDLE.
- States: IDLE, ASSERT, RELEASE, SETTLE, PULSE, WAIT, REPORT.
- IDLE: outputs hold. `go`=1 → ASSERT; clear `pass` and `lat_meas`.
- ASSERT (1 cycle): `rst_out`=all ones → RELEASE, step index k=0.
- RELEASE: on entry to step k, deassert `rst_out[k]`; stay REL_GAP cycles; k=NUM_RST−1 done → SETTLE. Released bits stay low.
- SETTLE (REL_GAP cycles): `chain_out`=1 in any cycle sets sticky `dirty`; then → PULSE.
- PULSE (1 cycle): `start`=1, `en`=1; latency counter cleared to 0 → WAIT.
- WAIT: `en`=1, counter +1 per cycle (counter value is 1 in the first WAIT cycle). First cycle with `chain_out`=1: `lat_meas`=counter, `pass`=(counter==CHAIN_LAT) & !`dirty` → REPORT. Counter reaching TO_CYCLES with no `chain_out`: `lat_meas`=all ones, `pass`=0 → REPORT.
- REPORT (1 cycle): `done`=1, `en`=0 → IDLE. `rst_out` stays released in IDLE.
- `go` while busy: ignored, no queuing. `go` held high in IDLE after REPORT: new run starts.
- `rst1` asserted mid-run: immediate abort to reset values, all domains re-asserted.
- Counter saturates; no wrap-around.

## Timing
- `go` sampled high at cycle T: ASSERT at T+1 (`busy`=1, all `rst_out`=1).
- `rst_out[k]` falls at T+2+k·REL_GAP (defaults: T+2, T+6, …, T+22).
- SETTLE T+2+NUM_RST·REL_GAP (T+26) for REL_GAP cycles; PULSE at T+30.
- Ideal chain: `chain_out` high at T+38 (count 8); `lat_meas`/`pass` valid and `done`=1 at T+39; `busy`=0 at T+40.
- Timeout: `done` at T+30+TO_CYCLES+1 (T+63 default).
- `go`→`done` latency independent of `chain_out` except the WAIT interval.

## Configuration
- `HOP_SEQ_REVERSE_EN` defined: release order descending (`rst_out[NUM_RST−1]` first, `rst_out[0]` last), sink-first bring-up; timing per step identical.
- Undefined: ascending order as above.

## Test plan
- Ideal 8-stage chain model, `go` at T=10 → `rst_out` falls at 12,16,…,32; `start` at 40; `done` at 49, `lat_meas`=8, `pass`=1.
- Chain model with 9-cycle delay → `lat_meas`=9, `pass`=0, `done` at 50.
- `chain_out` tied 0 → `done` at T+63, `lat_meas`=63, `pass`=0.
- `chain_out` forced 1 for one cycle during SETTLE, ideal chain otherwise → `lat_meas`=8, `pass`=0.
- `rst1` pulsed at T+20 mid-RELEASE → all `rst_out`=1, `busy`=0 same cycle; second `go` completes normally with `pass`=1; `go` pulses during busy have no effect.
- With `HOP_SEQ_REVERSE_EN`: `rst_out[5]` falls at T+2, `rst_out[0]` at T+22; result as first case.

Source files
------------

// File: rtl/hop_chain_seq.sv
// Bring-up sequencer for the hop flop chain: staged reset release, idle check, latency probe.
// Optional HOP_SEQ_REVERSE_EN releases the reset domains sink-first (descending index).
module hop_chain_seq #(
  parameter int NUM_RST   = 6,
  parameter int REL_GAP   = 4,
  parameter int CHAIN_LAT = 8,
  parameter int TO_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic               clock0,
  input  logic               rst1,
  input  logic               go,
  input  logic               chain_out,
  output logic [NUM_RST-1:0] rst_out,
  output logic               start,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   lat_meas
);

  localparam int KW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
  localparam int GW = (REL_GAP > 1) ? $clog2(REL_GAP) : 1;
  localparam logic [KW-1:0]    K_LAST  = KW'(NUM_RST - 1);
  localparam logic [GW-1:0]    G_LAST  = GW'(REL_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(CHAIN_LAT);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TO_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, ASSERT, RELEASE, SETTLE, PULSE, WAIT, REPORT} state_t;

  state_t           state;
  logic [KW-1:0]    step;
  logic [GW-1:0]    gap;
  logic [CNT_W-1:0] cnt;
  logic             dirty;

  // Release step -> domain index
  function automatic logic [KW-1:0] dom(input logic [KW-1:0] k);
`ifdef HOP_SEQ_REVERSE_EN
    return K_LAST - k;
`else
    return k;
`endif
  endfunction

  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      state    <= IDLE;
      rst_out  <= '1;
      start    <= 1'b0;
      en       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      lat_meas <= '0;
      step     <= '0;
      gap      <= '0;
      cnt      <= '0;
      dirty    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state    <= ASSERT;
          busy     <= 1'b1;
          rst_out  <= '1;
          pass     <= 1'b0;
          lat_meas <= '0;
          dirty    <= 1'b0;
        end
        ASSERT: begin
          state            <= RELEASE;
          step             <= '0;
          gap              <= '0;
          rst_out[dom('0)] <= 1'b0;
        end
        RELEASE: begin
          if (gap == G_LAST) begin
            gap <= '0;
            if (step == K_LAST) begin
              state <= SETTLE;
            end else begin
              step                     <= step + 1'b1;
              rst_out[dom(step + 1'b1)] <= 1'b0;
            end
          end else begin
            gap <= gap + 1'b1;
          end
        end
        SETTLE: begin
          // Any activity on an idle, freshly reset chain marks the run dirty
          if (chain_out) dirty <= 1'b1;
          if (gap == G_LAST) begin
            gap   <= '0;
            state <= PULSE;
            start <= 1'b1;
            en    <= 1'b1;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        PULSE: begin
          state <= WAIT;
          start <= 1'b0;
          cnt   <= CNT_W'(1);
        end
        WAIT: begin
          if (chain_out) begin
            state    <= REPORT;
            lat_meas <= cnt;
            pass     <= (cnt == CNT_LAT) && !dirty;
            done     <= 1'b1;
            en       <= 1'b0;
          end else if (cnt >= CNT_TO) begin
            state    <= REPORT;
            lat_meas <= CNT_MAX;
            pass     <= 1'b0;
            done     <= 1'b1;
            en       <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hop_chain_seq.sv
// Bench for hop_chain_seq: delay-line chain model, vector table, random runs, reset abort.
module tb_hop_chain_seq;
  localparam int NUM_RST = 6, REL_GAP = 4, CHAIN_LAT = 8, TO_CYCLES = 32, CNT_W = 6;
  localparam int VW = NUM_RST + CNT_W + 5;

  logic clock0 = 1'b0, rst1 = 1'b1, go = 1'b0, chain_out;
  logic [NUM_RST-1:0] rst_out;
  logic start, en, busy, done, pass;
  logic [CNT_W-1:0] lat_meas;

  hop_chain_seq #(.NUM_RST(NUM_RST), .REL_GAP(REL_GAP), .CHAIN_LAT(CHAIN_LAT),
                  .TO_CYCLES(TO_CYCLES), .CNT_W(CNT_W)) dut (
    .clock0(clock0), .rst1(rst1), .go(go), .chain_out(chain_out),
    .rst_out(rst_out), .start(start), .en(en), .busy(busy), .done(done),
    .pass(pass), .lat_meas(lat_meas));

  always #5 clock0 = ~clock0;

  int cyc = 0;
  always @(posedge clock0) cyc <= cyc + 1;

  // Chain model: delay line of `dly` cycles, cleared by its first-domain reset
  int dly = CHAIN_LAT;
  logic frc = 1'b0;
  logic [63:0] sr = '0;
  always @(posedge clock0) begin
    if (rst1 || rst_out[0]) sr <= '0;
    else                    sr <= {sr[62:0], start};
  end
  always_comb begin
    chain_out = frc;
    if (dly >= 1 && dly <= 64 && sr[dly-1]) chain_out = 1'b1;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string name, input int c, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, exp);
    end
  endtask

  function automatic int pos(input int k);
`ifdef HOP_SEQ_REVERSE_EN
    return NUM_RST - 1 - k;
`else
    return k;
`endif
  endfunction

  // Expected outputs in cycle c of a run whose go was sampled in cycle t
  function automatic logic [VW-1:0] expect_at(input int c, input int t, input int doff,
                                             input int elat, input bit epass);
    logic [NUM_RST-1:0] r;
    logic [CNT_W-1:0] l;
    for (int k = 0; k < NUM_RST; k++) r[k] = (c < t + 2 + pos(k) * REL_GAP);
    l = (c >= t + doff) ? CNT_W'(elat) : '0;
    return {r, (c == t + 30), (c >= t + 30 && c < t + doff),
            (c >= t + 1 && c <= t + doff), (c == t + doff),
            ((c >= t + doff) ? epass : 1'b0), l};
  endfunction

  function automatic logic [VW-1:0] actual();
    return {rst_out, start, en, busy, done, pass, lat_meas};
  endfunction

  // One full run; go sampled in the current cycle, checked through the first IDLE cycle
  task automatic run(input string name, input int d, input bit gl, input bit noise,
                     input int elat, input bit epass, input int doff);
    int t;
    dly = d;
    @(negedge clock0);
    t = cyc;
    go = 1'b1;
    for (int c = t + 1; c <= t + doff + 1; c++) begin
      @(negedge clock0);
      go  = (noise && c <= t + doff) ? ($urandom_range(0, 5) == 0) : 1'b0;
      frc = gl && (c == t + 27);
      chk(name, c - t, actual(), expect_at(c, t, doff, elat, epass));
    end
    frc = 1'b0;
    go = 1'b0;
  endtask

  typedef struct {
    string name; int d; bit gl; int lat; bit ps; int doff;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int d, elat, doff, t;
    bit gl, ep;
    tbl[0] = '{"ideal",      8, 1'b0,  8, 1'b1, 39};
    tbl[1] = '{"slow9",      9, 1'b0,  9, 1'b0, 40};
    tbl[2] = '{"tied0",      0, 1'b0, 63, 1'b0, 63};
    tbl[3] = '{"dirty",      8, 1'b1,  8, 1'b0, 39};
    tbl[4] = '{"fast1",      1, 1'b0,  1, 1'b0, 32};
    tbl[5] = '{"edge32",    32, 1'b0, 32, 1'b0, 63};
    tbl[6] = '{"late33",    33, 1'b0, 63, 1'b0, 63};

    repeat (3) @(negedge clock0);
    chk("reset", cyc, actual(), {{NUM_RST{1'b1}}, 5'b0, {CNT_W{1'b0}}});
    rst1 = 1'b0;
    repeat (2) @(negedge clock0);
    chk("idle", cyc, actual(), {{NUM_RST{1'b1}}, 5'b0, {CNT_W{1'b0}}});

    foreach (tbl[i]) run(tbl[i].name, tbl[i].d, tbl[i].gl, 1'b0, tbl[i].lat, tbl[i].ps, tbl[i].doff);

    // Abort mid-release: resets re-assert and busy drops in the same cycle
    dly = CHAIN_LAT;
    @(negedge clock0);
    t = cyc;
    go = 1'b1;
    @(negedge clock0);
    go = 1'b0;
    while (cyc < t + 20) @(negedge clock0);
    rst1 = 1'b1;
    #1;
    chk("abort", cyc - t, actual(), {{NUM_RST{1'b1}}, 5'b0, {CNT_W{1'b0}}});
    @(negedge clock0);
    rst1 = 1'b0;
    run("after_abort", CHAIN_LAT, 1'b0, 1'b1, CHAIN_LAT, 1'b1, 39);

    // Random runs against the latency rules
    for (int i = 0; i < 12; i++) begin
      d  = $urandom_range(0, 40);
      gl = ($urandom_range(0, 3) == 0);
      if (d >= 1 && d <= TO_CYCLES) begin
        elat = d;
        doff = 31 + d;
        ep   = (d == CHAIN_LAT) && !gl;
      end else begin
        elat = (1 << CNT_W) - 1;
        doff = 31 + TO_CYCLES;
        ep   = 1'b0;
      end
      run("rand", d, gl, 1'b1, elat, ep, doff);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
